// File: rtl/proj_sequencer.sv
// Operand/strobe sequencer for the 3x3 projection matrix-vector product.
// Optional divide stage enabled by defining PROJSEQ_DIVIDE_EN.
module proj_sequencer #(
  parameter int MULT_LAT = 4,
  parameter int ADD_LAT  = 4,
  parameter int DIV_LAT  = 6
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       mul_valid,
  output logic [1:0] mul_row,
  output logic [1:0] mul_col,
  output logic       prod_we,
  output logic [3:0] prod_idx,
  output logic       add_valid,
  output logic       add_op,
  output logic [1:0] add_row,
`ifdef PROJSEQ_DIVIDE_EN
  output logic       div_valid,
  output logic       div_sel,
  output logic       div_we,
  output logic       div_idx,
`endif
  output logic       sum_we,
  output logic [1:0] sum_row,
  output logic       res_we,
  output logic [1:0] res_row
);

`ifdef PROJSEQ_DIVIDE_EN
  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DIV, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;
`endif

  state_t state, state_n;

  logic [1:0] mr, mc;
  logic [3:0] idx_in;
  logic [8:0] p_av;
  logic [2:0] s_av;
  logic [2:0] iss0, iss1;
  logic [2:0] el0, el1;
  logic [1:0] res_cnt;
  logic       active;

  logic [MULT_LAT-1:0] mp_v;
  logic [3:0]          mp_idx [MULT_LAT];
  logic [ADD_LAT-1:0]  ap_v;
  logic [ADD_LAT-1:0]  ap_op;
  logic [1:0]          ap_row [ADD_LAT];

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign active    = (state == RUN) || (state == DRAIN);
  assign mul_valid = (state == RUN);
  assign mul_row   = mul_valid ? mr : 2'd0;
  assign mul_col   = mul_valid ? mc : 2'd0;
  assign idx_in    = {2'b00, mr} + {1'b0, mr, 1'b0} + {2'b00, mc};

  assign prod_we  = mp_v[MULT_LAT-1];
  assign prod_idx = prod_we ? mp_idx[MULT_LAT-1] : 4'd0;

  assign sum_we  = ap_v[ADD_LAT-1] & ~ap_op[ADD_LAT-1];
  assign res_we  = ap_v[ADD_LAT-1] &  ap_op[ADD_LAT-1];
  assign sum_row = sum_we ? ap_row[ADD_LAT-1] : 2'd0;
  assign res_row = res_we ? ap_row[ADD_LAT-1] : 2'd0;

  assign el0 = {p_av[6] & p_av[7],
                p_av[3] & p_av[4],
                p_av[0] & p_av[1]} & ~iss0;
  assign el1 = {p_av[8] & s_av[2],
                p_av[5] & s_av[1],
                p_av[2] & s_av[0]} & ~iss1;

  // op1 outranks op0 so a finishing row never waits behind a new one
  always_comb begin
    add_valid = 1'b0;
    add_op    = 1'b0;
    add_row   = 2'd0;
    if (active) begin
      if (|el1) begin
        add_valid = 1'b1;
        add_op    = 1'b1;
        add_row   = el1[0] ? 2'd0 : (el1[1] ? 2'd1 : 2'd2);
      end else if (|el0) begin
        add_valid = 1'b1;
        add_row   = el0[0] ? 2'd0 : (el0[1] ? 2'd1 : 2'd2);
      end
    end
  end

`ifdef PROJSEQ_DIVIDE_EN
  logic [1:0]         div_cnt;
  logic [DIV_LAT-1:0] dp_v;
  logic [DIV_LAT-1:0] dp_s;

  assign div_valid = (state == DIV) && !div_cnt[1];
  assign div_sel   = div_valid & div_cnt[0];
  assign div_we    = dp_v[DIV_LAT-1];
  assign div_idx   = div_we & dp_s[DIV_LAT-1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= 2'd0;
      dp_v    <= '0;
      dp_s    <= '0;
    end else begin
      dp_v[0] <= div_valid;
      dp_s[0] <= div_sel;
      for (int i = 1; i < DIV_LAT; i++) begin
        dp_v[i] <= dp_v[i-1];
        dp_s[i] <= dp_s[i-1];
      end
      if (state == DONE)
        div_cnt <= 2'd0;
      else if (div_valid)
        div_cnt <= div_cnt + 2'd1;
    end
  end
`else
  logic unused_div;
  assign unused_div = (DIV_LAT != 0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (mr == 2'd2 && mc == 2'd2) state_n = DRAIN;
`ifdef PROJSEQ_DIVIDE_EN
      DRAIN: if (res_we && res_cnt == 2'd2) state_n = DIV;
      DIV:   if (div_we && div_idx) state_n = DONE;
`else
      DRAIN: if (res_we && res_cnt == 2'd2) state_n = DONE;
`endif
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mr <= 2'd0;
      mc <= 2'd0;
    end else if (mul_valid) begin
      if (mc == 2'd2) begin
        mc <= 2'd0;
        mr <= (mr == 2'd2) ? 2'd0 : mr + 2'd1;
      end else begin
        mc <= mc + 2'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mp_v <= '0;
      ap_v <= '0;
      ap_op <= '0;
      for (int i = 0; i < MULT_LAT; i++) mp_idx[i] <= 4'd0;
      for (int i = 0; i < ADD_LAT; i++) ap_row[i] <= 2'd0;
    end else begin
      mp_v[0]   <= mul_valid;
      mp_idx[0] <= idx_in;
      for (int i = 1; i < MULT_LAT; i++) begin
        mp_v[i]   <= mp_v[i-1];
        mp_idx[i] <= mp_idx[i-1];
      end
      ap_v[0]   <= add_valid;
      ap_op[0]  <= add_op;
      ap_row[0] <= add_row;
      for (int i = 1; i < ADD_LAT; i++) begin
        ap_v[i]   <= ap_v[i-1];
        ap_op[i]  <= ap_op[i-1];
        ap_row[i] <= ap_row[i-1];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      p_av    <= '0;
      s_av    <= '0;
      iss0    <= '0;
      iss1    <= '0;
      res_cnt <= 2'd0;
    end else if (state == DONE) begin
      p_av    <= '0;
      s_av    <= '0;
      iss0    <= '0;
      iss1    <= '0;
      res_cnt <= 2'd0;
    end else begin
      if (prod_we) p_av[prod_idx] <= 1'b1;
      if (sum_we)  s_av[sum_row]  <= 1'b1;
      if (add_valid) begin
        if (add_op) iss1[add_row] <= 1'b1;
        else        iss0[add_row] <= 1'b1;
      end
      if (res_we) res_cnt <= res_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_proj_sequencer.sv
// Directed bench for proj_sequencer: per-cycle vector table plus
// hand-written reset, collision and restart sequences.
module tb_proj_sequencer;

`ifdef PROJSEQ_DIVIDE_EN
  localparam int DONE_K = 31;
  localparam int NV     = 36;
  localparam int DONE2  = 27;
`else
  localparam int DONE_K = 23;
  localparam int NV     = 30;
  localparam int DONE2  = 19;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mul_valid;
    logic [1:0] mul_row;
    logic [1:0] mul_col;
    logic       prod_we;
    logic [3:0] prod_idx;
    logic       add_valid;
    logic       add_op;
    logic [1:0] add_row;
    logic       sum_we;
    logic [1:0] sum_row;
    logic       res_we;
    logic [1:0] res_row;
    logic       div_valid;
    logic       div_sel;
    logic       div_we;
    logic       div_idx;
  } out_t;

  typedef struct {
    logic start;
    out_t exp;
  } vec_t;

  logic clk, rst_n, start, start2;

  logic       busy, done, mul_valid, prod_we;
  logic       add_valid, add_op, sum_we, res_we;
  logic [1:0] mul_row, mul_col, add_row, sum_row, res_row;
  logic [3:0] prod_idx;
  logic       b_busy, b_done, b_mul_valid, b_prod_we;
  logic       b_add_valid, b_add_op, b_sum_we, b_res_we;
  logic [1:0] b_mul_row, b_mul_col, b_add_row, b_sum_row, b_res_row;
  logic [3:0] b_prod_idx;
`ifdef PROJSEQ_DIVIDE_EN
  logic div_valid, div_sel, div_we, div_idx;
  logic b_div_valid, b_div_sel, b_div_we, b_div_idx;
`endif

  int checks = 0;
  int passed = 0;
  vec_t tbl [NV];

  proj_sequencer dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start),
    .busy(busy), .done(done),
    .mul_valid(mul_valid), .mul_row(mul_row), .mul_col(mul_col),
    .prod_we(prod_we), .prod_idx(prod_idx),
    .add_valid(add_valid), .add_op(add_op), .add_row(add_row),
`ifdef PROJSEQ_DIVIDE_EN
    .div_valid(div_valid), .div_sel(div_sel),
    .div_we(div_we), .div_idx(div_idx),
`endif
    .sum_we(sum_we), .sum_row(sum_row),
    .res_we(res_we), .res_row(res_row)
  );

  proj_sequencer #(.MULT_LAT(4), .ADD_LAT(2)) dut2 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start2),
    .busy(b_busy), .done(b_done),
    .mul_valid(b_mul_valid), .mul_row(b_mul_row), .mul_col(b_mul_col),
    .prod_we(b_prod_we), .prod_idx(b_prod_idx),
    .add_valid(b_add_valid), .add_op(b_add_op), .add_row(b_add_row),
`ifdef PROJSEQ_DIVIDE_EN
    .div_valid(b_div_valid), .div_sel(b_div_sel),
    .div_we(b_div_we), .div_idx(b_div_idx),
`endif
    .sum_we(b_sum_we), .sum_row(b_sum_row),
    .res_we(b_res_we), .res_row(b_res_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample1();
    out_t s;
    s = '0;
    s.busy = busy;           s.done = done;
    s.mul_valid = mul_valid; s.mul_row = mul_row;
    s.mul_col = mul_col;     s.prod_we = prod_we;
    s.prod_idx = prod_idx;   s.add_valid = add_valid;
    s.add_op = add_op;       s.add_row = add_row;
    s.sum_we = sum_we;       s.sum_row = sum_row;
    s.res_we = res_we;       s.res_row = res_row;
`ifdef PROJSEQ_DIVIDE_EN
    s.div_valid = div_valid; s.div_sel = div_sel;
    s.div_we = div_we;       s.div_idx = div_idx;
`endif
    return s;
  endfunction

  task automatic check(input string name, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
  endtask

  function automatic void set_add(int k, logic op, logic [1:0] r);
    tbl[k].exp.add_valid = 1'b1;
    tbl[k].exp.add_op    = op;
    tbl[k].exp.add_row   = r;
  endfunction

  task automatic run_table(input string name);
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      start = tbl[k].start;
      #1;
      check(name, k, 32'(sample1()), 32'(tbl[k].exp));
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  int ck [6] = '{7, 10, 11, 13, 14, 16};
  logic co [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] cr [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};

  initial begin
    // expected per-cycle outputs, default latencies, start at k=0
    // with ignored re-starts at k=5 and k=23
    for (int k = 0; k < NV; k++) begin
      tbl[k].start = (k == 0) || (k == 5) || (k == 23);
      tbl[k].exp = '0;
      tbl[k].exp.busy = (k >= 1) && (k <= DONE_K);
    end
    for (int k = 1; k <= 9; k++) begin
      tbl[k].exp.mul_valid = 1'b1;
      tbl[k].exp.mul_row   = 2'((k - 1) / 3);
      tbl[k].exp.mul_col   = 2'((k - 1) % 3);
    end
    for (int k = 5; k <= 13; k++) begin
      tbl[k].exp.prod_we  = 1'b1;
      tbl[k].exp.prod_idx = 4'(k - 5);
    end
    set_add(7,  1'b0, 2'd0);
    set_add(10, 1'b0, 2'd1);
    set_add(12, 1'b1, 2'd0);
    set_add(13, 1'b0, 2'd2);
    set_add(15, 1'b1, 2'd1);
    set_add(18, 1'b1, 2'd2);
    tbl[11].exp.sum_we = 1'b1; tbl[11].exp.sum_row = 2'd0;
    tbl[14].exp.sum_we = 1'b1; tbl[14].exp.sum_row = 2'd1;
    tbl[17].exp.sum_we = 1'b1; tbl[17].exp.sum_row = 2'd2;
    tbl[16].exp.res_we = 1'b1; tbl[16].exp.res_row = 2'd0;
    tbl[19].exp.res_we = 1'b1; tbl[19].exp.res_row = 2'd1;
    tbl[22].exp.res_we = 1'b1; tbl[22].exp.res_row = 2'd2;
    tbl[DONE_K].exp.done = 1'b1;
`ifdef PROJSEQ_DIVIDE_EN
    tbl[23].exp.div_valid = 1'b1;
    tbl[24].exp.div_valid = 1'b1; tbl[24].exp.div_sel = 1'b1;
    tbl[29].exp.div_we = 1'b1;
    tbl[30].exp.div_we = 1'b1;    tbl[30].exp.div_idx = 1'b1;
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", i, 32'(sample1()), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", i, 32'(sample1()), 32'd0);
    end

    run_table("default_run");

    begin
      int adds;
      logic [4:0] got, exp;
      adds = 0;
      for (int k = 0; k <= DONE2 + 3; k++) begin
        @(negedge clk);
        start2 = (k == 0);
        #1;
        exp = {(k == DONE2), 4'd0};
        for (int j = 0; j < 6; j++)
          if (ck[j] == k) exp[3:0] = {1'b1, co[j], cr[j]};
        got = {b_done, b_add_valid, b_add_op, b_add_row};
        if (b_add_valid) adds++;
        check("collision", k, 32'(got), 32'(exp));
      end
      start2 = 1'b0;
      check("collision_adds", 0, 32'(adds), 32'd6);
    end

    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_reset_hold", 8, 32'(sample1()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("mid_reset_quiet", i, 32'(sample1()), 32'd0);
    end

    run_table("rerun");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
